prog_loader: RTL and testbench
==============================

// Module: prog_loader
// PURPOSE
//  Upstream stage of the TIS execution core: accepts a framed instruction stream over a valid/ready
//  link and fills the core's 15-entry program store and pLength. Holds the core in reset while a
//  program loads and releases it only when a complete, valid program is in place.
//  A new frame may arrive at any time; it reloads the store and restarts the core.
// PARAMETERS
//  MAX_LEN   15       program slots; must match the core's prog depth
//  WORD_W    16       instruction / stream word width
//  MAGIC     12'hC0D  required value of header bits [15:4]
// PORTS
//  clk        in   1          clock
//  rst        in   1          synchronous, active-high reset
//  in_data    in   WORD_W     stream word (header, instructions[, checksum])
//  in_valid   in   1          in_data valid
//  in_ready   out  1          loader accepts in_data this cycle
//  prog       out  WORD_W x MAX_LEN  program store [0:MAX_LEN-1], to core
//  pLength    out  4          program length, to core
//  core_rst   out  1          reset to core; 1 while no valid program is committed
//  loaded     out  1          1 while a committed program runs
//  err        out  1          sticky frame error; cleared by next accepted header
// BEHAVIOUR
//  - Reset: prog all 16'h0000, pLength=0, core_rst=1, loaded=0, err=0, state IDLE, count=0.
//  - Transfer occurs on in_valid & in_ready. in_ready=1 in every state (no backpressure), 0 during rst.
//  - Header: in_data[15:4]==MAGIC and len=in_data[3:0] in 1..MAX_LEN.
//  - FSM: IDLE, LOAD, CSUM (macro only), RUN, ERR.
//  - IDLE/RUN/ERR + valid header: next cycle core_rst=1, loaded=0, err=0, all prog slots cleared
//    to 0, pLength<=len, count<=0 -> LOAD. Header with bad magic or len 0: err=1, core_rst=1,
//    loaded=0 -> ERR (store untouched). Any non-header word in these states is also a frame error.
//  - LOAD: word written to prog[count], count++. On word with count==pLength-1: -> RUN
//    (or CSUM with macro). Words are never interpreted as headers inside LOAD.
//  - RUN entry: core_rst=0 and loaded=1 in the cycle after the final word is accepted (1-cycle
//    latency, registered outputs). Core thus sees prog/pLength stable before leaving reset.
//  - count width 4 bits; count never exceeds MAX_LEN-1; no wrap.
//  - rst mid-frame: returns to reset values; partial frame discarded, next word must be a header.
//  - Header arriving while RUN: core is reset immediately (next cycle) and reload begins.
// CONFIGURATION
//  PROG_LOADER_CHECKSUM_EN defined: after the last instruction, FSM enters CSUM and expects one
//    word equal to XOR of all pLength instruction words. Match -> RUN next cycle. Mismatch ->
//    err=1, core_rst stays 1, -> ERR; store contents kept but never released to the core.
//  Undefined: no CSUM state; RUN follows the last instruction directly; no checksum word.
// STRUCTURE
//  Shared package tis_pkg: WORD_W, MAX_LEN, instr_t (logic [15:0]), MAGIC constant, length type
//    (logic [3:0]), loader state enum. Core opcode constants also live there.
//  No sub-module: single FSM + write-pointer + optional XOR accumulator in one file.
// TESTING
//  1. After rst: prog all 0, pLength=0, core_rst=1, loaded=0, err=0, in_ready=1.
//  2. Stream C0D3, 4801, 4802, 6000 -> cycle after 6000: prog[0..2]=4801,4802,6000,
//     prog[3..14]=0, pLength=3, core_rst=0, loaded=1.
//  3. Stream C0D0 (len 0) -> err=1, core_rst=1, prog unchanged; then C0D1,4801 -> err=0, RUN.
//  4. During RUN send C0D2 -> next cycle core_rst=1, loaded=0, all slots 0; 2 words -> RUN again.
//  5. rst after 2 of 5 words of C0D5 frame -> reset values; following 4801 (no header) -> err=1.
//  6. Macro on: C0D2,4801,4802,000 3 -> RUN; repeat with checksum 0004 -> err=1, core_rst=1.

Source files
------------

// File: rtl/tis_pkg.sv
// Shared TIS core types: stream word/length types, loader states, core opcodes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tis_pkg;

    localparam int          WORD_W  = 16;
    localparam int          MAX_LEN = 15;
    localparam logic [11:0] MAGIC   = 12'hC0D;

    typedef logic [15:0] instr_t;
    typedef logic [3:0]  len_t;

    // Loader FSM states; CSUM only exists when the checksum word is part of the frame
`ifdef PROG_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, LOAD, CSUM, RUN, ERR} ld_state_t;
`else
    typedef enum logic [2:0] {IDLE, LOAD, RUN, ERR} ld_state_t;
`endif

    // Core opcode field (instr[15:12]) values
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_MOV = 4'h4;
    localparam logic [3:0] OP_ADD = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;

    // A header carries the magic tag in [15:4] and a length of 1..max_len in [3:0]
    function automatic logic is_header(input instr_t w, input int max_len);
        return (w[15:4] == MAGIC) && (w[3:0] != 4'd0) && (int'(w[3:0]) <= max_len);
    endfunction

endpackage

// File: rtl/prog_loader.sv
// Frame loader: fills the core program store from a header+instructions stream, holds core in reset until committed.
// Latency: outputs registered; core leaves reset the cycle after the final frame word is accepted.
// Backpressure: none, in_ready is high whenever rst is low. Optional checksum word: PROG_LOADER_CHECKSUM_EN.
module prog_loader
    import tis_pkg::*;
#(
    parameter int          MAX_LEN = tis_pkg::MAX_LEN,
    parameter int          WORD_W  = tis_pkg::WORD_W,
    parameter logic [11:0] MAGIC   = tis_pkg::MAGIC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [WORD_W-1:0] prog [0:MAX_LEN-1],
    output logic [3:0]        pLength,
    output logic              core_rst,
    output logic              loaded,
    output logic              err
);

    ld_state_t state;
    len_t      count;
    logic      xfer;
    logic      hdr_ok;
    logic      last_word;

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [WORD_W-1:0] csum_acc;
`endif

    assign in_ready  = ~rst;
    assign xfer      = in_valid & in_ready;
    assign hdr_ok    = (in_data[WORD_W-1:4] == MAGIC) && (in_data[3:0] != 4'd0) &&
                       (int'(in_data[3:0]) <= MAX_LEN);
    assign last_word = (count == (pLength - 4'd1));

    // Frame FSM, write pointer, store and registered core controls
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            pLength  <= '0;
            core_rst <= 1'b1;
            loaded   <= 1'b0;
            err      <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) prog[i] <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum_acc <= '0;
`endif
        end else if (xfer) begin
            case (state)
                LOAD: begin
                    prog[count] <= in_data;
`ifdef PROG_LOADER_CHECKSUM_EN
                    csum_acc    <= csum_acc ^ in_data;
`endif
                    if (last_word) begin
                        // Hold count on the last word so it never passes MAX_LEN-1
`ifdef PROG_LOADER_CHECKSUM_EN
                        state    <= CSUM;
`else
                        state    <= RUN;
                        core_rst <= 1'b0;
                        loaded   <= 1'b1;
`endif
                    end else begin
                        count <= count + 4'd1;
                    end
                end
`ifdef PROG_LOADER_CHECKSUM_EN
                CSUM: begin
                    if (in_data == csum_acc) begin
                        state    <= RUN;
                        core_rst <= 1'b0;
                        loaded   <= 1'b1;
                    end else begin
                        // Store is kept for inspection but never released to the core
                        state    <= ERR;
                        err      <= 1'b1;
                    end
                end
`endif
                default: begin
                    // IDLE, RUN, ERR: only a good header is legal; anything else is a frame error
                    core_rst <= 1'b1;
                    loaded   <= 1'b0;
                    if (hdr_ok) begin
                        state   <= LOAD;
                        err     <= 1'b0;
                        pLength <= in_data[3:0];
                        count   <= '0;
                        for (int i = 0; i < MAX_LEN; i++) prog[i] <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                        csum_acc <= '0;
`endif
                    end else begin
                        state <= ERR;
                        err   <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: table of stream words with expected control outputs, scoreboarded per word.
// Latency: each expectation is checked one cycle after its word is accepted.
// Backpressure: none expected; in_ready checked around reset.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] prog [0:14];
    logic [3:0]  pLength;
    logic        core_rst;
    logic        loaded;
    logic        err;

    always #5 clk = ~clk;

    prog_loader dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .prog     (prog),
        .pLength  (pLength),
        .core_rst (core_rst),
        .loaded   (loaded),
        .err      (err)
    );

    typedef struct packed {
        logic [15:0] d;
        logic        cr;
        logic        ld;
        logic        er;
        logic [3:0]  pl;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   ntests = 0;
    int   nfail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [15:0] d, input logic cr, input logic ld,
                       input logic er, input logic [3:0] pl);
        vec_t v;
        v.d = d; v.cr = cr; v.ld = ld; v.er = er; v.pl = pl;
        vecs.push_back(v);
    endtask

    // Drive one word for one cycle, then pop its expectation and compare
    task automatic apply(input int i);
        vec_t e;
        in_data  = vecs[i].d;
        in_valid = 1'b1;
        sb.push_back(vecs[i]);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 16'h0000;
        if (sb.size() == 0) begin
            chk($sformatf("v%0d scoreboard empty", i), 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk($sformatf("v%0d core_rst", i), 32'(core_rst), 32'(e.cr));
            chk($sformatf("v%0d loaded", i),   32'(loaded),   32'(e.ld));
            chk($sformatf("v%0d err", i),      32'(err),      32'(e.er));
            chk($sformatf("v%0d pLength", i),  32'(pLength),  32'(e.pl));
            chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'd1);
        end
    endtask

    task automatic run(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) apply(i);
    endtask

    task automatic chk_slot(input string nm, input int idx, input logic [15:0] exp);
        chk($sformatf("%s prog[%0d]", nm, idx), 32'(prog[idx]), 32'(exp));
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        chk("in_ready during rst", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
    endtask

    task automatic check_reset(input string nm);
        for (int i = 0; i < 15; i++) chk_slot(nm, i, 16'h0000);
        chk({nm, " pLength"},  32'(pLength),  32'd0);
        chk({nm, " core_rst"}, 32'(core_rst), 32'd1);
        chk({nm, " loaded"},   32'(loaded),   32'd0);
        chk({nm, " err"},      32'(err),      32'd0);
        chk({nm, " in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
`ifdef PROG_LOADER_CHECKSUM_EN
        add(16'hC0D2, 1, 0, 0, 2);   // 0
        add(16'h4801, 1, 0, 0, 2);   // 1
        add(16'h4802, 1, 0, 0, 2);   // 2  now waiting for checksum
        add(16'h0003, 0, 1, 0, 2);   // 3  good checksum -> RUN
        add(16'hC0D2, 1, 0, 0, 2);   // 4
        add(16'h4801, 1, 0, 0, 2);   // 5
        add(16'h4802, 1, 0, 0, 2);   // 6
        add(16'h0004, 1, 0, 1, 2);   // 7  bad checksum -> ERR
        add(16'hC0D1, 1, 0, 0, 1);   // 8
        add(16'h4801, 1, 0, 0, 1);   // 9
        add(16'h4801, 0, 1, 0, 1);   // 10
`else
        add(16'hC0D3, 1, 0, 0, 3);   // 0
        add(16'h4801, 1, 0, 0, 3);   // 1
        add(16'h4802, 1, 0, 0, 3);   // 2
        add(16'h6000, 0, 1, 0, 3);   // 3  -> RUN
        add(16'hC0D0, 1, 0, 1, 3);   // 4  len 0
        add(16'hC0D1, 1, 0, 0, 1);   // 5
        add(16'h4801, 0, 1, 0, 1);   // 6
        add(16'hC0D2, 1, 0, 0, 2);   // 7  header during RUN
        add(16'h5000, 1, 0, 0, 2);   // 8
        add(16'h5001, 0, 1, 0, 2);   // 9
        add(16'hABC3, 1, 0, 1, 2);   // 10 bad magic
        add(16'hC0DF, 1, 0, 0, 15);  // 11 full-length frame
        for (int i = 0; i < 14; i++) add(16'h7000 + 16'(i), 1, 0, 0, 15);  // 12..25
        add(16'h700E, 0, 1, 0, 15);  // 26
        add(16'h1234, 1, 0, 1, 15);  // 27 stray word in RUN
        add(16'hC0D5, 1, 0, 0, 5);   // 28
        add(16'h4801, 1, 0, 0, 5);   // 29
        add(16'h4802, 1, 0, 0, 5);   // 30
        add(16'h4801, 1, 0, 1, 0);   // 31 after rst: no header
`endif

        do_reset();
        check_reset("reset");

`ifdef PROG_LOADER_CHECKSUM_EN
        run(0, 3);
        chk_slot("csum ok", 0, 16'h4801);
        chk_slot("csum ok", 1, 16'h4802);
        run(4, 7);
        chk_slot("csum bad kept", 0, 16'h4801);
        chk_slot("csum bad kept", 1, 16'h4802);
        run(8, 10);
        chk_slot("recover", 0, 16'h4801);
`else
        run(0, 3);
        chk_slot("frame3", 0, 16'h4801);
        chk_slot("frame3", 1, 16'h4802);
        chk_slot("frame3", 2, 16'h6000);
        for (int i = 3; i < 15; i++) chk_slot("frame3", i, 16'h0000);

        run(4, 4);
        chk_slot("len0 untouched", 0, 16'h4801);
        chk_slot("len0 untouched", 2, 16'h6000);

        run(5, 6);
        chk_slot("frame1", 0, 16'h4801);
        chk_slot("frame1", 1, 16'h0000);

        run(7, 7);
        for (int i = 0; i < 15; i++) chk_slot("reload clear", i, 16'h0000);
        run(8, 9);
        chk_slot("frame2", 0, 16'h5000);
        chk_slot("frame2", 1, 16'h5001);

        // Idle cycles must not disturb a running program
        repeat (3) @(posedge clk);
        #1;
        chk("idle loaded", 32'(loaded), 32'd1);
        chk("idle core_rst", 32'(core_rst), 32'd0);

        run(10, 10);
        chk_slot("badmagic untouched", 0, 16'h5000);

        run(11, 26);
        chk_slot("frame15", 0, 16'h7000);
        chk_slot("frame15", 7, 16'h7007);
        chk_slot("frame15", 14, 16'h700E);

        run(27, 27);
        chk_slot("stray untouched", 14, 16'h700E);

        run(28, 30);
        do_reset();
        check_reset("midframe rst");
        run(31, 31);
`endif

        chk("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
